// File: rtl/gpio_debounce_pkg.sv
// Shared defaults for the GPIO pad debouncer: widths of the per-channel
// stability counter and of the tick prescaler.
package gpio_debounce_pkg;

    localparam int unsigned CntWidthDefault   = 8;
    localparam int unsigned PrescWidthDefault = 16;

endpackage : gpio_debounce_pkg

// File: rtl/gpio_debounce_chk.sv
// Property checks on the debouncer outputs: no unknowns once out of reset,
// and a channel never reports a change and a glitch in the same cycle.
module gpio_debounce_chk #(
    parameter int unsigned NumGpios = 32
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic [NumGpios-1:0] gpio_o,
    input logic [NumGpios-1:0] change_o,
    input logic [NumGpios-1:0] glitch_o
);

    a_outputs_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({gpio_o, change_o, glitch_o}));

    a_change_glitch_exclusive : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((change_o & glitch_o) == {NumGpios{1'b0}}));

endmodule : gpio_debounce_chk

// File: rtl/gpio_debounce_tick.sv
// Free-running prescaler that produces the shared debounce time base.
// The tick is asserted whenever the count has reached the programmed
// period; the >= compare lets the period be lowered mid-count without
// the counter running off to wrap-around.
module gpio_debounce_tick
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned PrescWidth = PrescWidthDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PrescWidth-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PrescWidth-1:0] pc_r;

    assign tick_o = (pc_r >= prescale_i);

    // Count up to the programmed period, then restart from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r <= {PrescWidth{1'b0}};
        end else if (tick_o) begin
            pc_r <= {PrescWidth{1'b0}};
        end else begin
            pc_r <= pc_r + {{(PrescWidth-1){1'b0}}, 1'b1};
        end
    end

endmodule : gpio_debounce_tick

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for a vector of asynchronous inputs. Each bit is
// synchronised independently; no cross-bit coherence is implied.
module prim_flop_2sync #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_r;
    logic [Width-1:0] stage2_r;

    // Two back-to-back capture stages to resolve metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_r <= {Width{1'b0}};
            stage2_r <= {Width{1'b0}};
        end else begin
            stage1_r <= d_i;
            stage2_r <= stage1_r;
        end
    end

    assign q_o = stage2_r;

endmodule : prim_flop_2sync

// File: rtl/gpio_debounce.sv
// Pad-side input conditioning: synchronises the raw GPIO pads and debounces
// each channel against a shared programmable tick. Each channel produces a
// clean level, a one-cycle change pulse and a one-cycle glitch pulse.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned NumGpios   = 32,
    parameter int unsigned CntWidth   = CntWidthDefault,
    parameter int unsigned PrescWidth = PrescWidthDefault,
    parameter bit          SyncOn     = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumGpios-1:0]   enable_i,
    input  logic [PrescWidth-1:0] prescale_i,
    input  logic [CntWidth-1:0]   thresh_i,
    input  logic [NumGpios-1:0]   gpio_i,
    output logic [NumGpios-1:0]   gpio_o,
    output logic [NumGpios-1:0]   change_o,
    output logic [NumGpios-1:0]   glitch_o
);

    logic [NumGpios-1:0] sample_s;
    logic                tick_s;
    logic [CntWidth:0]   thresh_eff_s;

    if (SyncOn) begin : gen_sync
        prim_flop_2sync #(
            .Width (NumGpios)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (gpio_i),
            .q_o    (sample_s)
        );
    end else begin : gen_nosync
        assign sample_s = gpio_i;
    end

    gpio_debounce_tick #(
        .PrescWidth (PrescWidth)
    ) u_tick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .prescale_i (prescale_i),
        .tick_o     (tick_s)
    );

    // A zero threshold behaves as one tick; one extra bit keeps the
    // cnt+1 compare free of wrap-around at the top of the range.
    assign thresh_eff_s = (thresh_i == {CntWidth{1'b0}}) ?
                          {{CntWidth{1'b0}}, 1'b1} : {1'b0, thresh_i};

    for (genvar i = 0; i < NumGpios; i++) begin : gen_chan
        logic [CntWidth-1:0] cnt_r;
        logic [CntWidth-1:0] cnt_d_s;
        logic [CntWidth:0]   cnt_inc_s;
        logic                level_r;
        logic                level_d_s;
        logic                change_r;
        logic                glitch_r;
        logic                glitch_d_s;

        assign cnt_inc_s = {1'b0, cnt_r} + {{CntWidth{1'b0}}, 1'b1};

        // Next level / count / glitch: bypass follows the sample, debounce
        // needs thresh consecutive ticks of a differing sample; a return to
        // the held level wins over a coincident tick.
        always_comb begin
            level_d_s  = level_r;
            cnt_d_s    = cnt_r;
            glitch_d_s = 1'b0;
            if (!enable_i[i]) begin
                level_d_s = sample_s[i];
                cnt_d_s   = {CntWidth{1'b0}};
            end else if (sample_s[i] == level_r) begin
                cnt_d_s    = {CntWidth{1'b0}};
                glitch_d_s = (cnt_r != {CntWidth{1'b0}});
            end else if (tick_s) begin
                if (cnt_inc_s >= thresh_eff_s) begin
                    level_d_s = sample_s[i];
                    cnt_d_s   = {CntWidth{1'b0}};
                end else begin
                    cnt_d_s   = cnt_inc_s[CntWidth-1:0];
                end
            end else begin
                cnt_d_s = cnt_r;
            end
        end

        // Channel state and registered pulses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_r    <= {CntWidth{1'b0}};
                level_r  <= 1'b0;
                change_r <= 1'b0;
                glitch_r <= 1'b0;
            end else begin
                cnt_r    <= cnt_d_s;
                level_r  <= level_d_s;
                change_r <= (level_d_s != level_r);
                glitch_r <= glitch_d_s;
            end
        end

        assign gpio_o[i]   = level_r;
        assign change_o[i] = change_r;
        assign glitch_o[i] = glitch_r;
    end

    gpio_debounce_chk #(
        .NumGpios (NumGpios)
    ) u_chk (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .gpio_o   (gpio_o),
        .change_o (change_o),
        .glitch_o (glitch_o)
    );

endmodule : gpio_debounce

// File: doc/gpio_debounce.md
# gpio_debounce

Pad-side input conditioning stage that sits directly upstream of the GPIO controller's `cio_gpio_i` inputs. It synchronises up to 32 asynchronous pad inputs and debounces each one against a shared, programmable time base. The result is a clean level per pin, a one-cycle change pulse and a one-cycle glitch pulse. Configuration arrives as static sideband inputs from a top-level control register, not over a register bus.

## Interface
- `NumGpios`, default 32: number of channels.
- `CntWidth`, default 8: width of the per-channel stability counter and of `thresh_i`.
- `PrescWidth`, default 16: width of the tick prescaler and of `prescale_i`.
- `SyncOn`, default 1: 1 instantiates 2-flop synchronisers on `gpio_i`; 0 samples directly.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  NumGpios  per-channel debounce enable; 0 selects bypass.
- `prescale_i`  in  PrescWidth  tick period minus 1; 0 gives a tick every cycle.
- `thresh_i`  in  CntWidth  number of consecutive ticks a new level must hold; 0 is treated as 1.
- `gpio_i`  in  NumGpios  raw pad inputs, asynchronous.
- `gpio_o`  out  NumGpios  debounced level; connects to `cio_gpio_i`.
- `change_o`  out  NumGpios  one-cycle pulse in the cycle `gpio_o` first shows a new value.
- `glitch_o`  out  NumGpios  one-cycle pulse when a pending change is abandoned.

## Operation
- **Synchronised sample.** `s[i]` is `gpio_i[i]` after the synchroniser, or the raw input when `SyncOn=0`.
- **Tick generator.**
  - Counter `pc` runs from 0 upward.
  - When `pc >= prescale_i`: `tick=1` and `pc<=0`; otherwise `pc<=pc+1`.
  - The `>=` compare makes it safe when `prescale_i` is lowered mid-count.
  - The tick generator free-runs and is independent of `enable_i`.
- **Per channel, bypass (`enable_i[i]=0`):**
  - `gpio_o[i] <= s[i]` every cycle.
  - `cnt[i] <= 0`.
  - `glitch_o[i]` never asserts.
- **Per channel, debounce (`enable_i[i]=1`):**
  - `s==gpio_o` and `cnt!=0`: `cnt<=0`, `glitch_o` pulses next cycle.
  - `s==gpio_o` and `cnt==0`: hold.
  - `s!=gpio_o` and no tick: hold `cnt`.
  - `s!=gpio_o` and tick, with `cnt+1 >= max(thresh_i,1)`: `gpio_o<=s`, `cnt<=0`.
  - `s!=gpio_o` and tick, otherwise: `cnt<=cnt+1`.
- **Bounds.**
  - `cnt` never exceeds `max(thresh_i,1)`, so it cannot wrap.
  - If `thresh_i` is lowered below the current `cnt`, the update fires on the next tick.
- **Change pulse.** `change_o[i]` is registered as `gpio_o_d != gpio_o_q` and is valid in both modes.
- **Enable changes mid-count.**
  - Enable falling: the pending count is dropped with no glitch pulse, and `gpio_o` follows `s` on the next edge.
  - Enable rising: counting starts from 0.
- **Reset values.** All of `gpio_o`, `change_o`, `glitch_o`, `cnt`, `pc` and the synchroniser flops reset to 0.
- **Power-up edge.** An input held at 1 out of reset is a normal edge: it is debounced and produces a `change_o` pulse.

## Timing
- The synchroniser adds 2 cycles when `SyncOn=1`, 0 otherwise.
- **Bypass latency.** A change in `s` at cycle c appears on `gpio_o` at c+1.
- **Debounce latency**, with effective threshold `T`:
  - `P=0`: a change in `s` at cycle c appears on `gpio_o` at exactly c+T, provided `s` is stable.
  - `P>0`: the delay is between (T-1)(P+1)+1 and T(P+1) cycles, depending on tick phase.
- **Change pulse timing.** `change_o` asserts in the same cycle as the new `gpio_o` value.
- **Glitch pulse timing.** `glitch_o` asserts 1 cycle after `s` returns to the old level.
- **Same-cycle tick and return.** If a tick coincides with `s` returning to the old level, the return wins: clear and glitch, no increment.

## Structure
- `gpio_debounce_pkg` holds only the default widths `CntWidth` and `PrescWidth`.
- Sub-module `gpio_debounce_tick` contains the prescaler and outputs the `tick` signal.
- Synchronisers use `prim_flop_2sync` under a `SyncOn` generate.
- Per-channel logic is a generate loop in the top module; there is no FSM beyond the counter and the held level.
- Assert that `gpio_o`, `change_o` and `glitch_o` are never X after reset.
- Assert that `change_o` and `glitch_o` are never high on the same channel in the same cycle.

## Test plan
- **Bypass.** `SyncOn=1`, `enable=0`, pin 0 goes 0→1 at cycle 10 → `gpio_o[0]=1` at cycle 13, `change_o[0]` high at cycle 13 only.
- **Clean edge.** `enable=1`, `P=0`, `T=4`, pin 3 goes 0→1 and is held → `gpio_o[3]` rises 6 cycles after the pad edge, one `change_o[3]` pulse, no `glitch_o`.
- **Glitch.** `P=0`, `T=4`, pin 5 pulses high for 3 cycles → `gpio_o[5]` stays 0, exactly one `glitch_o[5]` pulse, `change_o[5]` never asserts.
- **Prescaled edge.** `P=9`, `T=3`, pin 7 toggles and holds → `gpio_o[7]` changes within 21–30 cycles after the synchroniser output; pin 8 held 15 cycles → no change.
- **Reset mid-count.** Assert `rst_ni` mid-count → all outputs 0 immediately; after release a held-high input re-debounces from 0 with a full T-tick delay.
- **Mid-operation config.** Drop `enable_i[2]` mid-count → `gpio_o[2]` follows in 1 cycle, no glitch pulse. Change `prescale_i` from 100 to 0 mid-period → tick asserts on the next cycle.
